// File: rtl/branch_pc_ctrl.sv
// branch_pc_ctrl: fetch PC register, next-PC select and redirect flushes.
// Ports: clk/reset, EX branch, ID jump, load-use stall in; PC, PC_plus4, flushes, counters out.
module branch_pc_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Branch_hazard,
  input  logic [31:0]          EX_BranchTarget,
  input  logic                 ID_Jump,
  input  logic [31:0]          ID_JumpTarget,
  input  logic                 Load_use_stall,
  output logic [31:0]          PC,
  output logic [31:0]          PC_plus4,
  output logic                 IF_ID_Flush,
  output logic                 ID_EX_Flush,
  output logic [CNT_WIDTH-1:0] Branch_count,
  output logic [CNT_WIDTH-1:0] Stall_count
);

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_JUMP,
    SEL_STALL,
    SEL_BRANCH
  } sel_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  sel_t        sel;
  logic [31:0] next_pc;

  assign PC_plus4 = PC + 32'd4;

  // A branch in EX means the ID instruction is wrong-path,
  // so it outranks both the stall and the jump.
  always_comb begin
    sel = SEL_SEQ;
    priority case (1'b1)
      Branch_hazard:  sel = SEL_BRANCH;
      Load_use_stall: sel = SEL_STALL;
      ID_Jump:        sel = SEL_JUMP;
      default:        sel = SEL_SEQ;
    endcase
  end

  always_comb begin
    next_pc     = PC_plus4;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    unique case (sel)
      SEL_BRANCH: begin
        next_pc     = EX_BranchTarget;
        IF_ID_Flush = 1'b1;
        ID_EX_Flush = 1'b1;
      end
      SEL_STALL: begin
        next_pc     = PC;
        ID_EX_Flush = 1'b1;
      end
      SEL_JUMP: begin
        next_pc     = ID_JumpTarget;
        IF_ID_Flush = 1'b1;
      end
      default: next_pc = PC_plus4;
    endcase
    if (reset) begin
      IF_ID_Flush = 1'b0;
      ID_EX_Flush = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      PC           <= RESET_PC;
      Branch_count <= '0;
      Stall_count  <= '0;
    end else begin
      PC <= next_pc;
      if (sel == SEL_BRANCH && Branch_count != CNT_MAX)
        Branch_count <= Branch_count + CNT_ONE;
      if (sel == SEL_STALL && Stall_count != CNT_MAX)
        Stall_count <= Stall_count + CNT_ONE;
    end
  end

endmodule
